packet_injector: RTL and testbench

Source-side network interface that packetizes core traffic into the flit stream consumed by a router input port. It accepts a packet descriptor (destination), then FlitPerPacket-1 payload words. It emits one head flit, then body flits, then one tail flit on a registered valid/ready output. It sits between a processing element and router input lane data_in_bus[INDEX].

---
 rtl/packet_injector.sv | 157 +++++++++++++++
 tb/tb_packet_injector.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_injector.sv
// packet_injector: turns a destination descriptor plus FlitPerPacket-1 payload words into head/body/tail flits.
// Latency: a handshaked descriptor or payload word appears on data_out on the following cycle.
// Backpressure: the output register holds while valid_out && !ready_out; pkt_ready/payload_ready drop with it.
module packet_injector #(
    parameter int N             = 100,
    parameter int DEST_WIDTH    = $clog2(N),
    parameter int INDEX         = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int PAYLOAD_WIDTH = DATA_WIDTH - TYPE_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DEST_WIDTH-1:0]    pkt_dest,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [PAYLOAD_WIDTH-1:0] payload_data,
    input  logic                     payload_valid,
    output logic                     payload_ready,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     packets_sent,
    output logic                     dest_err
);

    // flit_cnt must hold FlitPerPacket after the tail increment
    localparam int FC_WIDTH   = $clog2(FlitPerPacket + 1);
    localparam int DEST_CMP_W = DEST_WIDTH + 1;

    localparam logic [TYPE_WIDTH-1:0] TYPE_HEAD  = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TYPE_BODY  = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TYPE_TAIL  = TYPE_WIDTH'(3);
    localparam logic [FC_WIDTH-1:0]   LAST_IDX   = FC_WIDTH'(FlitPerPacket - 1);
    localparam logic [DEST_CMP_W-1:0] DEST_LIMIT = DEST_CMP_W'(N);
    localparam logic [DEST_WIDTH-1:0] SRC_ID     = DEST_WIDTH'(INDEX);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t                  r_state;
    logic [FC_WIDTH-1:0]     r_flit_cnt;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_valid_out;
    logic                    r_run;
    logic [CNT_WIDTH-1:0]    r_packets_sent;
    logic                    r_dest_err;

    logic                    w_slot_free;
    logic                    w_pkt_hs;
    logic                    w_pay_hs;
    logic                    w_last_flit;
    logic                    w_tail_hs;
    logic                    w_bad_dest;
    logic [DATA_WIDTH-1:0]   w_head_flit;
    logic [DATA_WIDTH-1:0]   w_pay_flit;

    // The output register can take a new flit when empty or being drained this cycle.
    // r_run keeps both ready signals low while reset is asserted.
    assign w_slot_free   = !r_valid_out || ready_out;
    assign pkt_ready     = r_run && (r_state == S_IDLE) && w_slot_free;
    assign payload_ready = r_run && (r_state == S_PAYLOAD) && w_slot_free;
    assign w_pkt_hs      = pkt_valid && pkt_ready;
    assign w_pay_hs      = payload_valid && payload_ready;
    assign w_last_flit   = (r_flit_cnt >= LAST_IDX);
    assign w_tail_hs     = r_valid_out && ready_out &&
                           (r_data_out[DATA_WIDTH-1 -: TYPE_WIDTH] == TYPE_TAIL);
    assign w_bad_dest    = ({1'b0, pkt_dest} >= DEST_LIMIT);

    assign data_out      = r_data_out;
    assign valid_out     = r_valid_out;
    assign busy          = (r_state == S_PAYLOAD) || r_valid_out;
    assign packets_sent  = r_packets_sent;
    assign dest_err      = r_dest_err;

    // Head flit: type, source node, destination node; remaining bits zero
    always_comb begin
        w_head_flit = '0;
        w_head_flit[DATA_WIDTH-1 -: TYPE_WIDTH]     = TYPE_HEAD;
        w_head_flit[2*DEST_WIDTH-1 -: DEST_WIDTH]   = SRC_ID;
        w_head_flit[DEST_WIDTH-1:0]                 = pkt_dest;
    end

    // Body/tail flit: the last payload word of a packet is tagged TAIL
    always_comb begin
        w_pay_flit = '0;
        w_pay_flit[DATA_WIDTH-1 -: TYPE_WIDTH] = w_last_flit ? TYPE_TAIL : TYPE_BODY;
        w_pay_flit[PAYLOAD_WIDTH-1:0]          = payload_data;
    end

    // Ready gate: released on the first clock edge after reset deasserts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Packetizer FSM with the registered flit output; a load in the same cycle overrides the drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_flit_cnt  <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            if (ready_out) begin
                r_valid_out <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pkt_hs) begin
                        r_data_out  <= w_head_flit;
                        r_valid_out <= 1'b1;
                        r_flit_cnt  <= FC_WIDTH'(1);
                        r_state     <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pay_hs) begin
                        r_data_out  <= w_pay_flit;
                        r_valid_out <= 1'b1;
                        r_flit_cnt  <= r_flit_cnt + FC_WIDTH'(1);
                        if (w_last_flit) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Count tails as they leave the output register; wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_packets_sent <= '0;
        end else if (w_tail_hs) begin
            r_packets_sent <= r_packets_sent + CNT_WIDTH'(1);
        end
    end

    // Sticky flag for out-of-range destinations; the packet itself is sent unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dest_err <= 1'b0;
        end else if (w_pkt_hs && w_bad_dest) begin
            r_dest_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Testbench for packet_injector: default configuration plus a FlitPerPacket=2, CNT_WIDTH=4 instance.
// Flits are predicted from handshaked inputs into a queue and popped when the DUT hands a flit off.
`timescale 1ns/1ps
module tb_packet_injector;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic [6:0]  pkt_dest;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [29:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_out;
    logic        busy;
    logic [15:0] packets_sent;
    logic        dest_err;

    // two-flit instance
    logic [6:0]  b_pkt_dest;
    logic        b_pkt_valid;
    logic        b_pkt_ready;
    logic [29:0] b_payload_data;
    logic        b_payload_valid;
    logic        b_payload_ready;
    logic [31:0] b_data_out;
    logic        b_valid_out;
    logic        b_ready_out;
    logic        b_busy;
    logic [3:0]  b_packets_sent;
    logic        b_dest_err;

    packet_injector dut (
        .clk(clk), .rst(rst),
        .pkt_dest(pkt_dest), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .payload_data(payload_data), .payload_valid(payload_valid), .payload_ready(payload_ready),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .busy(busy), .packets_sent(packets_sent), .dest_err(dest_err)
    );

    packet_injector #(.FlitPerPacket(2), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst),
        .pkt_dest(b_pkt_dest), .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready),
        .payload_data(b_payload_data), .payload_valid(b_payload_valid), .payload_ready(b_payload_ready),
        .data_out(b_data_out), .valid_out(b_valid_out), .ready_out(b_ready_out),
        .busy(b_busy), .packets_sent(b_packets_sent), .dest_err(b_dest_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_qb[$];
    logic [31:0] out_dat_q[$];
    int          out_cyc_q[$];
    int          m_flit   = 0;
    int          m_flit_b = 0;
    int          b_out_cnt = 0;

    typedef struct {
        logic [6:0]  dest;
        logic [29:0] base;
        logic [31:0] exp_head;
        logic        exp_err;
    } vec_t;
    vec_t vecs[4];

    logic [31:0] single_exp[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: handshake not seen within budget", name);
    endtask

    function automatic logic [31:0] head_f(input logic [6:0] d);
        head_f = {2'b01, 16'h0000, 7'd1, d};
    endfunction

    // cycle counter used to verify back-to-back flit hand-off
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the default instance: pop on output handshake, predict on input handshake
    always @(negedge clk) begin
        if (rst) begin
            if (valid_out && ready_out) begin
                out_cyc_q.push_back(cyc);
                out_dat_q.push_back(data_out);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: actual %0h expected no flit", data_out);
                end else begin
                    check("sb_flit", {32'h0, data_out}, {32'h0, exp_q.pop_front()});
                end
            end
            if (pkt_valid && pkt_ready) begin
                exp_q.push_back(head_f(pkt_dest));
                m_flit = 1;
            end
            if (payload_valid && payload_ready) begin
                exp_q.push_back({(m_flit < 5) ? 2'b10 : 2'b11, payload_data});
                m_flit++;
            end
        end
    end

    // Scoreboard for the two-flit instance
    always @(negedge clk) begin
        if (rst) begin
            if (b_valid_out && b_ready_out) begin
                b_out_cnt++;
                if (exp_qb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_b_unexpected: actual %0h expected no flit", b_data_out);
                end else begin
                    check("sb_b_flit", {32'h0, b_data_out}, {32'h0, exp_qb.pop_front()});
                end
            end
            if (b_pkt_valid && b_pkt_ready) begin
                exp_qb.push_back(head_f(b_pkt_dest));
                m_flit_b = 1;
            end
            if (b_payload_valid && b_payload_ready) begin
                exp_qb.push_back({(m_flit_b < 1) ? 2'b10 : 2'b11, b_payload_data});
                m_flit_b++;
            end
        end
    end

    task automatic send_desc(input logic [6:0] d);
        int  t  = 0;
        logic hs = 1'b0;
        pkt_valid = 1'b1;
        pkt_dest  = d;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = pkt_ready;
            t++;
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
        if (!hs) timeout("desc");
    endtask

    task automatic send_payloads(input logic [29:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            int  t  = 0;
            logic hs = 1'b0;
            payload_valid = 1'b1;
            payload_data  = base + 30'(i);
            while (!hs && t < 50) begin
                @(negedge clk);
                hs = payload_ready;
                t++;
                @(posedge clk);
                #1;
            end
            if (!hs) timeout("payload");
        end
        payload_valid = 1'b0;
    endtask

    task automatic send_pkt_b(input logic [6:0] d, input logic [29:0] p);
        int  t  = 0;
        logic hs = 1'b0;
        b_pkt_valid = 1'b1;
        b_pkt_dest  = d;
        while (!hs && t < 50) begin
            @(negedge clk); hs = b_pkt_ready; t++;
            @(posedge clk); #1;
        end
        b_pkt_valid = 1'b0;
        if (!hs) timeout("b_desc");
        hs = 1'b0;
        t  = 0;
        b_payload_valid = 1'b1;
        b_payload_data  = p;
        while (!hs && t < 50) begin
            @(negedge clk); hs = b_payload_ready; t++;
            @(posedge clk); #1;
        end
        b_payload_valid = 1'b0;
        if (!hs) timeout("b_payload");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid_out"},     {63'h0, valid_out},     64'h0);
        check({tag, "_data_out"},      {32'h0, data_out},      64'h0);
        check({tag, "_pkt_ready"},     {63'h0, pkt_ready},     64'h0);
        check({tag, "_payload_ready"}, {63'h0, payload_ready}, 64'h0);
        check({tag, "_busy"},          {63'h0, busy},          64'h0);
        check({tag, "_packets_sent"},  {48'h0, packets_sent},  64'h0);
        check({tag, "_dest_err"},      {63'h0, dest_err},      64'h0);
    endtask

    // Watchdog: the run is short; anything this long is a hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{dest: 7'd5,   base: 30'h100, exp_head: 32'h40000085, exp_err: 1'b0};
        vecs[1] = '{dest: 7'd99,  base: 30'h200, exp_head: 32'h400000E3, exp_err: 1'b0};
        vecs[2] = '{dest: 7'd100, base: 30'h300, exp_head: 32'h400000E4, exp_err: 1'b1};
        vecs[3] = '{dest: 7'd0,   base: 30'h400, exp_head: 32'h40000080, exp_err: 1'b1};
        single_exp = '{32'h400000A5, 32'h80000001, 32'h80000002,
                       32'h80000003, 32'h80000004, 32'hC0000005};

        rst = 1'b0;
        pkt_dest = '0; pkt_valid = 1'b0; payload_data = '0; payload_valid = 1'b0; ready_out = 1'b1;
        b_pkt_dest = '0; b_pkt_valid = 1'b0; b_payload_data = '0; b_payload_valid = 1'b0; b_ready_out = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        check("rst0_b_valid_out", {63'h0, b_valid_out}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("run_pkt_ready", {63'h0, pkt_ready}, 64'h1);
        check("run_payload_ready", {63'h0, payload_ready}, 64'h0);
        @(posedge clk); #1;

        // single packet, dest 37
        out_cyc_q.delete();
        out_dat_q.delete();
        send_desc(7'd37);
        send_payloads(30'h1, 5);
        @(negedge clk);
        check("single_tail_data", {32'h0, data_out}, {32'h0, 32'hC0000005});
        check("single_tail_busy", {63'h0, busy}, 64'h1);
        @(negedge clk);
        check("single_busy_fall", {63'h0, busy}, 64'h0);
        check("single_valid_fall", {63'h0, valid_out}, 64'h0);
        check("single_pkts", {48'h0, packets_sent}, 64'd1);
        check("single_nflits", 64'(out_dat_q.size()), 64'd6);
        if (out_dat_q.size() == 6) begin
            for (int i = 0; i < 6; i++) check("single_seq", {32'h0, out_dat_q[i]}, {32'h0, single_exp[i]});
            check("single_consec", 64'(out_cyc_q[5] - out_cyc_q[0]), 64'd5);
        end
        @(posedge clk); #1;

        // backpressure on the head flit, with junk payload offered during the stall
        ready_out = 1'b0;
        send_desc(7'd37);
        payload_valid = 1'b1;
        payload_data  = 30'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", {32'h0, data_out}, {32'h0, 32'h400000A5});
            check("bp_valid", {63'h0, valid_out}, 64'h1);
            check("bp_payload_ready", {63'h0, payload_ready}, 64'h0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        send_payloads(30'h10, 5);
        repeat (2) @(negedge clk);
        check("bp_pkts", {48'h0, packets_sent}, 64'd2);
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // back-to-back packets from the vector table, including an out-of-range destination
        out_cyc_q.delete();
        out_dat_q.delete();
        for (int v = 0; v < 4; v++) begin
            send_desc(vecs[v].dest);
            check("vec_dest_err", {63'h0, dest_err}, {63'h0, vecs[v].exp_err});
            send_payloads(vecs[v].base, 5);
        end
        repeat (2) @(negedge clk);
        check("b2b_nflits", 64'(out_dat_q.size()), 64'd24);
        if (out_dat_q.size() == 24) begin
            for (int v = 0; v < 4; v++) check("vec_head", {32'h0, out_dat_q[v*6]}, {32'h0, vecs[v].exp_head});
            check("b2b_consec", 64'(out_cyc_q[23] - out_cyc_q[0]), 64'd23);
        end
        check("b2b_pkts", {48'h0, packets_sent}, 64'd6);
        @(posedge clk); #1;

        // reset clears the sticky error and the counter
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_values("rst1");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // reset after three flits have been loaded
        send_desc(7'd7);
        send_payloads(30'h500, 2);
        rst = 1'b0;
        #1;
        check("midrst_valid", {63'h0, valid_out}, 64'h0);
        check("midrst_pkts", {48'h0, packets_sent}, 64'd0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        out_dat_q.delete();
        send_desc(7'd9);
        send_payloads(30'h600, 5);
        repeat (2) @(negedge clk);
        check("midrst_nflits", 64'(out_dat_q.size()), 64'd6);
        if (out_dat_q.size() > 0) check("midrst_head", {32'h0, out_dat_q[0]}, {32'h0, 32'h40000089});
        check("midrst_pkts_after", {48'h0, packets_sent}, 64'd1);
        @(posedge clk); #1;

        // two-flit packets and counter wrap on the second instance
        for (int k = 0; k < 17; k++) begin
            send_pkt_b(7'(k), 30'(k + 32));
            if (k == 15) begin
                repeat (2) @(negedge clk);
                check("b_wrap16", {60'h0, b_packets_sent}, 64'd0);
                @(posedge clk); #1;
            end
        end
        repeat (2) @(negedge clk);
        check("b_pkts17", {60'h0, b_packets_sent}, 64'd1);
        check("b_nflits", 64'(b_out_cnt), 64'd34);
        check("b_drained", 64'(exp_qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
